ctl_round: RTL

CTL_ROUND -- requirements
Module: ctl_round

---
 rtl/ctl_round.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ctl_round.sv
// ctl_round: round/duck sequencer for the duck-hunt game.
// One FSM walks each round through GAP -> LAUNCH -> FLY -> RESOLVE per duck,
// then holds a ROUND_END banner and either advances the round or ends the game.
// A single frame counter times every wait and is cleared on each state change.
module ctl_round #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int MAX_ROUND       = 9,
    parameter int GAP_FRAMES      = 60,
    parameter int FLY_FRAMES      = 300,
    parameter int RESOLVE_FRAMES  = 120,
    parameter int END_FRAMES      = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       game_start,
    input  logic       pause,
    input  logic       hit,
    input  logic       duck_show,
    output logic       duck_launch,
    output logic       duck_escape,
    output logic [3:0] round,
    output logic [3:0] duck_idx,
    output logic [3:0] hits_in_round,
    output logic       round_end,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {
        IDLE, GAP, LAUNCH, FLY, RESOLVE, ROUND_END, GAME_OVER
    } state_t;

    // A K-frame wait completes on the K-th counted frame, i.e. when the
    // counter already holds K-1 and another unpaused frame arrives.
    localparam logic [9:0] GAP_LAST  = 10'(GAP_FRAMES - 1);
    localparam logic [9:0] FLY_LAST  = 10'(FLY_FRAMES - 1);
    localparam logic [9:0] RES_LAST  = 10'(RESOLVE_FRAMES - 1);
    localparam logic [9:0] END_LAST  = 10'(END_FRAMES - 1);
    localparam logic [3:0] LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0] PASS      = 4'(PASS_HITS);
    localparam logic [3:0] LAST_RND  = 4'(MAX_ROUND);

    state_t     state;
    logic [9:0] cnt;
    logic       tick;
    logic       gap_done, fly_done, res_done, end_done;
    logic       shot;

    assign tick     = new_frame & ~pause;
    assign gap_done = tick && (cnt == GAP_LAST);
    assign fly_done = tick && (cnt == FLY_LAST);
    assign res_done = tick && (cnt == RES_LAST);
    assign end_done = tick && (cnt == END_LAST);
    // Hits only count while flying and unpaused; a hit beats a same-cycle timeout.
    assign shot     = hit & ~pause;

    // Sequencer: state, frame counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 10'd0;
            round         <= 4'd1;
            duck_idx      <= 4'd0;
            hits_in_round <= 4'd0;
            duck_launch   <= 1'b0;
            duck_escape   <= 1'b0;
            round_end     <= 1'b0;
            game_over     <= 1'b0;
            game_won      <= 1'b0;
        end else if (game_start) begin
            state         <= GAP;
            cnt           <= 10'd0;
            round         <= 4'd1;
            duck_idx      <= 4'd0;
            hits_in_round <= 4'd0;
            duck_launch   <= 1'b0;
            duck_escape   <= 1'b0;
            round_end     <= 1'b0;
            game_over     <= 1'b0;
            game_won      <= 1'b0;
        end else begin
            if (tick) cnt <= cnt + 10'd1;
            case (state)
                GAP: begin
                    if (gap_done) begin
                        state       <= LAUNCH;
                        cnt         <= 10'd0;
                        duck_launch <= 1'b1;
                    end
                end
                LAUNCH: begin
                    // Leaves after one cycle regardless of pause so the pulse stays single.
                    state       <= FLY;
                    cnt         <= 10'd0;
                    duck_launch <= 1'b0;
                end
                FLY: begin
                    if (shot) begin
                        state         <= RESOLVE;
                        cnt           <= 10'd0;
                        hits_in_round <= (hits_in_round == 4'd15) ? 4'd15 : hits_in_round + 4'd1;
                    end else if (fly_done) begin
                        state       <= RESOLVE;
                        cnt         <= 10'd0;
                        duck_escape <= 1'b1;
                    end
                end
                RESOLVE: begin
                    if (!duck_show || res_done) begin
                        cnt         <= 10'd0;
                        duck_escape <= 1'b0;
                        if (duck_idx < LAST_DUCK) begin
                            state    <= GAP;
                            duck_idx <= duck_idx + 4'd1;
                        end else begin
                            state     <= ROUND_END;
                            round_end <= 1'b1;
                        end
                    end
                end
                ROUND_END: begin
                    if (end_done) begin
                        cnt       <= 10'd0;
                        round_end <= 1'b0;
                        if (hits_in_round < PASS) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            game_won  <= 1'b0;
                        end else if (round >= LAST_RND) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            game_won  <= 1'b1;
                        end else begin
                            state         <= GAP;
                            round         <= round + 4'd1;
                            duck_idx      <= 4'd0;
                            hits_in_round <= 4'd0;
                        end
                    end
                end
                default: begin
                    // IDLE and GAME_OVER wait for game_start with the counter parked.
                    cnt <= 10'd0;
                end
            endcase
        end
    end

endmodule
